peripheral_dma: RTL and testbench

- Memory-to-memory word-copy engine with two bus faces.
- Configured by the CPU through the standard peripheral register interface (cs/addr/rd/wr/d_in/d_out).
- Moves data as an initiator on the same native memory bus the CPU drives: mem_addr/mem_rdata/mem_rstrb/mem_wdata/mem_wmask with rbusy/wbusy flow control.
- Arbitration against the CPU is done at SOC level and is outside this block. The block drives idle values whenever it is not transferring.

---
 rtl/peripheral_dma.sv | 183 ++++++++++++++++++
 tb/tb_peripheral_dma.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_dma.sv
// Memory-to-memory word-copy engine: CPU-programmed register face plus a
// native-bus initiator face that reads one word, then writes it, per step.
module peripheral_dma #(
  parameter int unsigned LEN_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] d_in,
  input  logic        cs,
  input  logic [4:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] d_out,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        mem_rstrb,
  input  logic        mem_rbusy,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_wbusy,
  output logic        irq
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RD    = 2'd1;
  localparam logic [1:0] S_RWAIT = 2'd2;
  localparam logic [1:0] S_WR    = 2'd3;

  localparam logic [4:0] A_SRC    = 5'h00;
  localparam logic [4:0] A_DST    = 5'h04;
  localparam logic [4:0] A_LEN    = 5'h08;
  localparam logic [4:0] A_CTRL   = 5'h0C;
  localparam logic [4:0] A_STATUS = 5'h10;
  localparam logic [4:0] A_REMAIN = 5'h14;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  logic [1:0]       state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      wsrc_q, wsrc_d;
  logic [31:0]      wdst_q, wdst_d;
  logic [LEN_W-1:0] remain_q, remain_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      d_out_q, d_out_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic             abort_pend_q, abort_pend_d;

  logic reg_wr, reg_rd, busy, start_req, abort_req, abort_now;

  always_comb begin
    reg_wr    = cs & wr;
    reg_rd    = cs & rd;
    busy      = (state_q != S_IDLE);
    start_req = reg_wr && (addr == A_CTRL) && d_in[0];
    abort_req = reg_wr && (addr == A_CTRL) && d_in[1];
    // An abort arriving on the very edge a word completes still ends the run there.
    abort_now = abort_pend_q | (abort_req & busy);

    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    len_d        = len_q;
    wsrc_d       = wsrc_q;
    wdst_d       = wdst_q;
    remain_d     = remain_q;
    wdata_d      = wdata_q;
    d_out_d      = d_out_q;
    done_d       = done_q;
    aborted_d    = aborted_q;
    abort_pend_d = abort_pend_q;

    if (reg_rd) begin
      case (addr)
        A_SRC:    d_out_d = src_q;
        A_DST:    d_out_d = dst_q;
        A_LEN:    d_out_d = 32'(len_q);
        A_STATUS: d_out_d = {29'd0, aborted_q, done_q, busy};
        A_REMAIN: d_out_d = 32'(remain_q);
        default:  d_out_d = '0;
      endcase
    end

    if (reg_wr && !busy) begin
      case (addr)
        A_SRC:   src_d = {d_in[31:2], 2'b00};
        A_DST:   dst_d = {d_in[31:2], 2'b00};
        A_LEN:   len_d = d_in[LEN_W-1:0];
        default: ;
      endcase
    end

    if (abort_req && busy) abort_pend_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          aborted_d    = 1'b0;
          abort_pend_d = 1'b0;
          if (len_q != '0) begin
            wsrc_d   = src_q;
            wdst_d   = dst_q;
            remain_d = len_q;
            done_d   = 1'b0;
            state_d  = S_RD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_RD: state_d = S_RWAIT;
      S_RWAIT: begin
        if (!mem_rbusy) begin
          wdata_d = mem_rdata;
          state_d = S_WR;
        end
      end
      S_WR: begin
        if (!mem_wbusy) begin
          remain_d = (remain_q != '0) ? remain_q - LEN_ONE : '0;
          wsrc_d   = wsrc_q + 32'd4;
          wdst_d   = wdst_q + 32'd4;
          if (remain_q <= LEN_ONE || abort_now) begin
            state_d      = S_IDLE;
            abort_pend_d = 1'b0;
            done_d       = ~abort_now;
            aborted_d    = abort_now;
          end else begin
            state_d = S_RD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      wsrc_q       <= '0;
      wdst_q       <= '0;
      remain_q     <= '0;
      wdata_q      <= '0;
      d_out_q      <= '0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      wsrc_q       <= wsrc_d;
      wdst_q       <= wdst_d;
      remain_q     <= remain_d;
      wdata_q      <= wdata_d;
      d_out_q      <= d_out_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  always_comb begin
    mem_rstrb = (state_q == S_RD);
    mem_wmask = (state_q == S_WR) ? 4'hF : 4'h0;
    case (state_q)
      S_RD, S_RWAIT: mem_addr = wsrc_q;
      S_WR:          mem_addr = wdst_q;
      default:       mem_addr = '0;
    endcase
  end

  assign mem_wdata = wdata_q;
  assign d_out     = d_out_q;
  assign irq       = done_q;

endmodule

// File: tb/tb_peripheral_dma.sv
// Directed bench for peripheral_dma with a small stallable memory target model.
module tb_peripheral_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] d_in;
  logic        cs, rd, wr;
  logic [4:0]  addr;
  logic [31:0] d_out;
  logic [31:0] mem_addr, mem_rdata, mem_wdata;
  logic        mem_rstrb, mem_rbusy, mem_wbusy;
  logic [3:0]  mem_wmask;
  logic        irq;

  int checks = 0;
  int errors = 0;

  // target model configuration (driven only by the stimulus process)
  logic [31:0] rstall_addr, wstall_addr;
  int          rstall_n, wstall_n;

  // target model state
  logic [31:0] raddr;
  int          rcnt, wcnt;
  int          nreads, nwrites, bad_mask, unstable, stall_wcycles, wm_cycles;
  logic        prev_wm;
  logic [31:0] prev_addr, prev_wdata;
  logic [31:0] wlog_addr [0:15];
  logic [31:0] wlog_data [0:15];

  peripheral_dma #(.LEN_W(16)) dut (
    .clk(clk), .reset(reset), .d_in(d_in), .cs(cs), .addr(addr), .rd(rd), .wr(wr),
    .d_out(d_out), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rstrb(mem_rstrb),
    .mem_rbusy(mem_rbusy), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_wbusy(mem_wbusy), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pattern(input logic [31:0] a);
    return ((a - 32'h100) >> 2) + 32'hA;
  endfunction

  assign mem_rdata = pattern(raddr);
  assign mem_rbusy = (rcnt != 0);
  assign mem_wbusy = (mem_wmask != 4'h0) && (mem_addr == wstall_addr) && (wcnt < wstall_n);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      raddr <= '0; rcnt <= 0; wcnt <= 0; nreads <= 0; nwrites <= 0;
      bad_mask <= 0; unstable <= 0; stall_wcycles <= 0; wm_cycles <= 0;
      prev_wm <= 1'b0; prev_addr <= '0; prev_wdata <= '0;
    end else begin
      if (mem_rstrb) begin
        nreads <= nreads + 1;
        raddr  <= mem_addr;
        rcnt   <= (mem_addr == rstall_addr) ? rstall_n : 0;
      end else if (rcnt != 0) begin
        rcnt <= rcnt - 1;
      end
      if (mem_wmask != 4'h0) begin
        wm_cycles <= wm_cycles + 1;
        if (mem_wmask != 4'hF) bad_mask <= bad_mask + 1;
        if (mem_addr == wstall_addr) stall_wcycles <= stall_wcycles + 1;
        if (prev_wm && mem_addr == prev_addr && mem_wdata != prev_wdata) unstable <= unstable + 1;
        if (mem_wbusy) wcnt <= wcnt + 1;
        else if (nwrites < 16) begin
          wlog_addr[nwrites] <= mem_addr;
          wlog_data[nwrites] <= mem_wdata;
          nwrites <= nwrites + 1;
        end
      end
      prev_wm    <= (mem_wmask != 4'h0) && mem_wbusy;
      prev_addr  <= mem_addr;
      prev_wdata <= mem_wdata;
    end
  end

  task automatic do_reset();
    cs = 0; rd = 0; wr = 0; addr = '0; d_in = '0;
    rstall_addr = 32'h1; wstall_addr = 32'h1; rstall_n = 0; wstall_n = 0;
    reset = 1'b1;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic reg_write(input logic [4:0] a, input logic [31:0] v);
    cs = 1; wr = 1; addr = a; d_in = v;
    @(negedge clk);
    cs = 0; wr = 0;
  endtask

  task automatic reg_read(input logic [4:0] a, output logic [31:0] v);
    cs = 1; rd = 1; addr = a;
    @(negedge clk);
    cs = 0; rd = 0;
    v = d_out;
  endtask

  task automatic wait_irq(input int limit, output int cyc);
    cyc = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if (irq) begin cyc = i; break; end
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    reset = 1'b1; cs = 0; rd = 0; wr = 0; addr = '0; d_in = '0;
    rstall_addr = 32'h1; wstall_addr = 32'h1; rstall_n = 0; wstall_n = 0;
    #1;
    checks++; if ({mem_rstrb, mem_wmask, irq} !== 6'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || d_out !== 32'h0) begin
      errors++; $display("FAIL reset_outputs: rstrb=%b wmask=%h irq=%b addr=%h wdata=%h d_out=%h expected all 0", mem_rstrb, mem_wmask, irq, mem_addr, mem_wdata, d_out);
    end
    @(negedge clk); reset = 1'b0; @(negedge clk);
    reg_read(5'h10, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_status: got %h expected 0", v); end
  endtask

  task automatic test_regs();
    logic [31:0] v;
    do_reset();
    reg_write(5'h00, 32'h0000_0103);
    reg_read(5'h00, v);
    checks++; if (v !== 32'h100) begin errors++; $display("FAIL src_align: got %h expected 00000100", v); end
    reg_write(5'h04, 32'h1234_567B);
    reg_read(5'h04, v);
    checks++; if (v !== 32'h1234_5678) begin errors++; $display("FAIL dst_align: got %h expected 12345678", v); end
    reg_write(5'h08, 32'hFFFF_0003);
    reg_read(5'h08, v);
    checks++; if (v !== 32'h3) begin errors++; $display("FAIL len_width: got %h expected 00000003", v); end
    reg_read(5'h0C, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL ctrl_read: got %h expected 0", v); end
    reg_write(5'h18, 32'hFFFF_FFFF);
    reg_read(5'h18, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL unmapped: got %h expected 0", v); end
    // simultaneous write and read of SRC returns the pre-write value
    cs = 1; wr = 1; rd = 1; addr = 5'h00; d_in = 32'h777;
    @(negedge clk);
    cs = 0; wr = 0; rd = 0;
    checks++; if (d_out !== 32'h100) begin errors++; $display("FAIL rw_same_cycle: got %h expected 00000100", d_out); end
    reg_read(5'h00, v);
    checks++; if (v !== 32'h774) begin errors++; $display("FAIL rw_after: got %h expected 00000774", v); end
  endtask

  task automatic test_happy();
    logic [31:0] v;
    int lat;
    do_reset();
    reg_write(5'h00, 32'h100);
    reg_write(5'h04, 32'h200);
    reg_write(5'h08, 32'd3);
    reg_write(5'h0C, 32'h1);
    checks++; if (mem_rstrb !== 1'b1 || mem_addr !== 32'h100) begin
      errors++; $display("FAIL first_rstrb: rstrb=%b addr=%h expected 1 00000100", mem_rstrb, mem_addr);
    end
    wait_irq(40, lat);
    checks++; if (lat != 9) begin errors++; $display("FAIL happy_latency: got %0d expected 9", lat); end
    checks++; if (nwrites != 3 || nreads != 3) begin errors++; $display("FAIL happy_count: writes=%0d reads=%0d expected 3 3", nwrites, nreads); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (wlog_addr[i] !== 32'h200 + 32'(4*i) || wlog_data[i] !== 32'hA + 32'(i)) begin
        errors++; $display("FAIL happy_word%0d: got %h@%h expected %h@%h", i, wlog_data[i], wlog_addr[i], 32'hA + 32'(i), 32'h200 + 32'(4*i));
      end
    end
    reg_read(5'h10, v);
    checks++; if (v !== 32'h2 || irq !== 1'b1) begin errors++; $display("FAIL happy_status: status=%h irq=%b expected 2 1", v, irq); end
    reg_read(5'h14, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL happy_remain: got %h expected 0", v); end
  endtask

  task automatic test_zero_len();
    logic [31:0] v;
    do_reset();
    reg_write(5'h0C, 32'h1);
    reg_read(5'h10, v);
    checks++; if (v !== 32'h2 || irq !== 1'b1) begin errors++; $display("FAIL zero_status: status=%h irq=%b expected 2 1", v, irq); end
    reg_write(5'h0C, 32'h2);
    reg_read(5'h10, v);
    checks++; if (v !== 32'h2) begin errors++; $display("FAIL idle_abort: status=%h expected 2", v); end
    repeat (5) @(negedge clk);
    checks++; if (nreads != 0 || wm_cycles != 0) begin errors++; $display("FAIL zero_bus: reads=%0d wmask_cycles=%0d expected 0 0", nreads, wm_cycles); end
    reg_write(5'h08, 32'd1);
    reg_write(5'h0C, 32'h1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b expected 0", irq); end
  endtask

  task automatic test_stall();
    int lat;
    do_reset();
    rstall_addr = 32'h300; rstall_n = 4;
    wstall_addr = 32'h400; wstall_n = 3;
    reg_write(5'h00, 32'h300);
    reg_write(5'h04, 32'h400);
    reg_write(5'h08, 32'd2);
    reg_write(5'h0C, 32'h1);
    wait_irq(60, lat);
    checks++; if (lat != 13) begin errors++; $display("FAIL stall_latency: got %0d expected 13", lat); end
    checks++; if (nwrites != 2 || nreads != 2) begin errors++; $display("FAIL stall_count: writes=%0d reads=%0d expected 2 2", nwrites, nreads); end
    checks++; if (wlog_addr[0] !== 32'h400 || wlog_data[0] !== 32'h8A || wlog_addr[1] !== 32'h404 || wlog_data[1] !== 32'h8B) begin
      errors++; $display("FAIL stall_data: got %h@%h %h@%h expected 0000008a@00000400 0000008b@00000404", wlog_data[0], wlog_addr[0], wlog_data[1], wlog_addr[1]);
    end
    checks++; if (unstable != 0 || bad_mask != 0 || stall_wcycles != 4) begin
      errors++; $display("FAIL stall_hold: unstable=%0d bad_mask=%0d wr_cycles=%0d expected 0 0 4", unstable, bad_mask, stall_wcycles);
    end
  endtask

  task automatic test_abort();
    logic [31:0] v;
    int found;
    do_reset();
    rstall_addr = 32'h104; rstall_n = 3;
    reg_write(5'h00, 32'h100);
    reg_write(5'h04, 32'h200);
    reg_write(5'h08, 32'd5);
    reg_write(5'h0C, 32'h1);
    found = 0;
    for (int i = 0; i < 30; i++) begin
      if (mem_rstrb && mem_addr == 32'h104) begin found = 1; break; end
      @(negedge clk);
    end
    checks++; if (found != 1) begin errors++; $display("FAIL abort_word2_read: got %0d expected 1", found); end
    @(negedge clk);
    reg_write(5'h0C, 32'h2);
    repeat (30) @(negedge clk);
    checks++; if (nwrites != 2 || nreads != 2) begin errors++; $display("FAIL abort_count: writes=%0d reads=%0d expected 2 2", nwrites, nreads); end
    checks++; if (wlog_data[1] !== 32'hB || wlog_addr[1] !== 32'h204) begin errors++; $display("FAIL abort_word2: got %h@%h expected 0000000b@00000204", wlog_data[1], wlog_addr[1]); end
    reg_read(5'h10, v);
    checks++; if (v !== 32'h4 || irq !== 1'b0) begin errors++; $display("FAIL abort_status: status=%h irq=%b expected 4 0", v, irq); end
    reg_read(5'h14, v);
    checks++; if (v !== 32'h3) begin errors++; $display("FAIL abort_remain: got %h expected 3", v); end
  endtask

  task automatic test_busy_lockout();
    logic [31:0] v;
    int lat;
    do_reset();
    reg_write(5'h00, 32'h100);
    reg_write(5'h04, 32'h500);
    reg_write(5'h08, 32'd3);
    reg_write(5'h0C, 32'h1);
    reg_write(5'h00, 32'hDEAD_0000);
    reg_write(5'h0C, 32'h1);
    cs = 1; rd = 1; addr = 5'h00;
    #1;
    checks++; if (d_out !== 32'h0) begin errors++; $display("FAIL dout_before_edge: got %h expected 0", d_out); end
    @(negedge clk);
    cs = 0; rd = 0;
    checks++; if (d_out !== 32'h100) begin errors++; $display("FAIL busy_src_lock: got %h expected 00000100", d_out); end
    wait_irq(40, lat);
    repeat (10) @(negedge clk);
    checks++; if (nwrites != 3 || nreads != 3) begin errors++; $display("FAIL lock_count: writes=%0d reads=%0d expected 3 3", nwrites, nreads); end
    checks++; if (wlog_addr[2] !== 32'h508 || wlog_data[2] !== 32'hC || wlog_addr[0] !== 32'h500 || wlog_data[0] !== 32'hA) begin
      errors++; $display("FAIL lock_data: got %h@%h %h@%h expected 0000000a@00000500 0000000c@00000508", wlog_data[0], wlog_addr[0], wlog_data[2], wlog_addr[2]);
    end
  endtask

  task automatic test_wrap();
    int lat;
    do_reset();
    reg_write(5'h00, 32'hFFFF_FFFC);
    reg_write(5'h04, 32'h600);
    reg_write(5'h08, 32'd2);
    reg_write(5'h0C, 32'h1);
    wait_irq(30, lat);
    checks++; if (nwrites != 2 || wlog_data[0] !== 32'h3FFF_FFC9 || wlog_data[1] !== 32'h3FFF_FFCA || wlog_addr[1] !== 32'h604) begin
      errors++; $display("FAIL addr_wrap: n=%0d got %h %h@%h expected 3fffffc9 3fffffca@00000604", nwrites, wlog_data[0], wlog_data[1], wlog_addr[1]);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    logic [31:0] ra [0:4];
    int found;
    ra[0] = 32'h00; ra[1] = 32'h04; ra[2] = 32'h08; ra[3] = 32'h10; ra[4] = 32'h14;
    do_reset();
    wstall_addr = 32'h200; wstall_n = 5;
    reg_write(5'h00, 32'h100);
    reg_write(5'h04, 32'h200);
    reg_write(5'h08, 32'd3);
    reg_write(5'h0C, 32'h1);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_wmask == 4'hF) begin found = 1; break; end
      @(negedge clk);
    end
    checks++; if (found != 1) begin errors++; $display("FAIL mid_reach_wr: got %0d expected 1", found); end
    reset = 1'b1;
    #1;
    checks++; if (mem_wmask !== 4'h0 || mem_rstrb !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || irq !== 1'b0) begin
      errors++; $display("FAIL mid_reset_outputs: wmask=%h rstrb=%b addr=%h wdata=%h irq=%b expected 0", mem_wmask, mem_rstrb, mem_addr, mem_wdata, irq);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      reg_read(ra[i][4:0], v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL mid_reg_%0h: got %h expected 0", ra[i], v); end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_regs();
    test_happy();
    test_zero_len();
    test_stall();
    test_abort();
    test_busy_lockout();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
